// File: rtl/sm4_key_cache.sv
// Key-tag cache for the SM4 datapath: maps a key to the way holding its
// expanded round keys, allocating a victim way on a miss.
module sm4_key_cache #(
    parameter int unsigned entries_p   = 4,
    parameter int unsigned key_width_p = 128,
    parameter int unsigned repl_mode_p = 1,
    parameter int unsigned cnt_width_p = 16
) (
    input  logic                         clk_i,
    input  logic                         reset_n_i,
    input  logic [key_width_p-1:0]       key_i,
    input  logic                         v_i,
    output logic                         ready_o,
    output logic                         v_o,
    input  logic                         yumi_i,
    output logic                         hit_o,
    output logic [$clog2(entries_p)-1:0] way_o,
    input  logic                         invalidate_i,
    output logic [entries_p-1:0]         valid_o,
    output logic [cnt_width_p-1:0]       hit_cnt_o,
    output logic [cnt_width_p-1:0]       miss_cnt_o
);

    localparam int unsigned WayW = $clog2(entries_p);

    typedef enum logic [0:0] {StIdle, StResp} state_e;

    state_e                 state_q, state_d;
    logic [key_width_p-1:0] tag_q [entries_p];
    logic [key_width_p-1:0] tag_d [entries_p];
    logic [WayW-1:0]        age_q [entries_p];
    logic [WayW-1:0]        age_d [entries_p];
    logic [entries_p-1:0]   valid_q, valid_d;
    logic [WayW-1:0]        rr_q, rr_d;
    logic                   hit_q, hit_d;
    logic [WayW-1:0]        way_q, way_d;
    logic [cnt_width_p-1:0] hit_cnt_q, hit_cnt_d;
    logic [cnt_width_p-1:0] miss_cnt_q, miss_cnt_d;

    logic                   accept;
    logic [entries_p-1:0]   eff_valid;
    logic                   hit;
    logic                   any_inv;
    logic [WayW-1:0]        hit_way, inv_way, lru_way, victim, touch_way;

    assign ready_o    = (state_q == StIdle);
    assign v_o        = (state_q == StResp);
    assign hit_o      = hit_q;
    assign way_o      = way_q;
    assign valid_o    = valid_q;
    assign hit_cnt_o  = hit_cnt_q;
    assign miss_cnt_o = miss_cnt_q;
    assign accept     = v_i & ready_o;

    // Tag match and victim selection against the post-invalidate view.
    always_comb begin
        eff_valid = invalidate_i ? '0 : valid_q;
        hit       = 1'b0;
        any_inv   = 1'b0;
        hit_way   = '0;
        inv_way   = '0;
        lru_way   = '0;
        // Descending scan so the lowest index wins.
        for (int i = entries_p - 1; i >= 0; i--) begin
            if (eff_valid[i] && (tag_q[i] == key_i)) begin
                hit     = 1'b1;
                hit_way = WayW'(i);
            end
            if (!eff_valid[i]) begin
                any_inv = 1'b1;
                inv_way = WayW'(i);
            end
            if (age_q[i] == WayW'(entries_p - 1)) begin
                lru_way = WayW'(i);
            end
        end
        if (any_inv) begin
            victim = inv_way;
        end else if (repl_mode_p == 1) begin
            victim = lru_way;
        end else begin
            victim = rr_q;
        end
        touch_way = hit ? hit_way : victim;
    end

    // Next-state: FSM, result capture, install, LRU touch and statistics.
    always_comb begin
        state_d    = state_q;
        valid_d    = invalidate_i ? '0 : valid_q;
        tag_d      = tag_q;
        age_d      = age_q;
        rr_d       = rr_q;
        hit_d      = hit_q;
        way_d      = way_q;
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;

        unique case (state_q)
            StIdle:  if (v_i) state_d = StResp;
            StResp:  if (yumi_i) state_d = StIdle;
            default: state_d = StIdle;
        endcase

        if (accept) begin
            hit_d = hit;
            way_d = touch_way;
            if (hit) begin
                if (hit_cnt_q != '1) hit_cnt_d = hit_cnt_q + cnt_width_p'(1);
            end else begin
                // Install wins over a same-cycle invalidate for this way.
                tag_d[victim]   = key_i;
                valid_d[victim] = 1'b1;
                if (miss_cnt_q != '1) miss_cnt_d = miss_cnt_q + cnt_width_p'(1);
                if (!any_inv && (repl_mode_p == 0)) rr_d = rr_q + WayW'(1);
            end
            if (repl_mode_p == 1) begin
                for (int i = 0; i < entries_p; i++) begin
                    if (WayW'(i) == touch_way) begin
                        age_d[i] = '0;
                    end else if (age_q[i] < age_q[touch_way]) begin
                        age_d[i] = age_q[i] + WayW'(1);
                    end
                end
            end
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q    <= StIdle;
            valid_q    <= '0;
            rr_q       <= '0;
            hit_q      <= 1'b0;
            way_q      <= '0;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
            for (int i = 0; i < entries_p; i++) begin
                tag_q[i] <= '0;
                age_q[i] <= WayW'(i);
            end
        end else begin
            state_q    <= state_d;
            valid_q    <= valid_d;
            rr_q       <= rr_d;
            hit_q      <= hit_d;
            way_q      <= way_d;
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
            tag_q      <= tag_d;
            age_q      <= age_d;
        end
    end

endmodule

// File: tb/tb_sm4_key_cache.sv
// Directed bench: instance 0 = LRU, instance 1 = round-robin, instance 2 = LRU with 2-bit counters.
module tb_sm4_key_cache;

    localparam logic [127:0] KA = 128'h0123_4567_89ab_cdef_0000_0000_0000_00a1;
    localparam logic [127:0] KB = 128'h0123_4567_89ab_cdef_0000_0000_0000_00b2;
    localparam logic [127:0] KC = 128'h0123_4567_89ab_cdef_0000_0000_0000_00c3;
    localparam logic [127:0] KD = 128'h0123_4567_89ab_cdef_0000_0000_0000_00d4;
    localparam logic [127:0] KE = 128'h0123_4567_89ab_cdef_0000_0000_0000_00e5;
    localparam logic [127:0] KF = 128'h0123_4567_89ab_cdef_0000_0000_0000_00f6;
    localparam logic [127:0] KG = 128'h0123_4567_89ab_cdef_0000_0000_0000_0107;
    localparam logic [127:0] KH = 128'h0123_4567_89ab_cdef_0000_0000_0000_0118;
    localparam logic [127:0] KI = 128'h0123_4567_89ab_cdef_0000_0000_0000_0129;
    localparam logic [127:0] KX = 128'h0123_4567_89ab_cdef_0000_0000_0000_0fff;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [127:0] key_a   [3];
    logic         v_a     [3];
    logic         yumi_a  [3];
    logic         inv_a   [3];
    logic         ready_a [3];
    logic         vo_a    [3];
    logic         hit_a   [3];
    logic [1:0]   way_a   [3];
    logic [3:0]   valid_a [3];
    logic [15:0]  hcnt_a  [2];
    logic [15:0]  mcnt_a  [2];
    logic [1:0]   s_hcnt, s_mcnt;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    sm4_key_cache #(.entries_p(4), .key_width_p(128), .repl_mode_p(1), .cnt_width_p(16)) dut_lru (
        .clk_i(clk), .reset_n_i(rst_n), .key_i(key_a[0]), .v_i(v_a[0]), .ready_o(ready_a[0]),
        .v_o(vo_a[0]), .yumi_i(yumi_a[0]), .hit_o(hit_a[0]), .way_o(way_a[0]),
        .invalidate_i(inv_a[0]), .valid_o(valid_a[0]), .hit_cnt_o(hcnt_a[0]),
        .miss_cnt_o(mcnt_a[0])
    );

    sm4_key_cache #(.entries_p(4), .key_width_p(128), .repl_mode_p(0), .cnt_width_p(16)) dut_rr (
        .clk_i(clk), .reset_n_i(rst_n), .key_i(key_a[1]), .v_i(v_a[1]), .ready_o(ready_a[1]),
        .v_o(vo_a[1]), .yumi_i(yumi_a[1]), .hit_o(hit_a[1]), .way_o(way_a[1]),
        .invalidate_i(inv_a[1]), .valid_o(valid_a[1]), .hit_cnt_o(hcnt_a[1]),
        .miss_cnt_o(mcnt_a[1])
    );

    sm4_key_cache #(.entries_p(4), .key_width_p(128), .repl_mode_p(1), .cnt_width_p(2)) dut_sat (
        .clk_i(clk), .reset_n_i(rst_n), .key_i(key_a[2]), .v_i(v_a[2]), .ready_o(ready_a[2]),
        .v_o(vo_a[2]), .yumi_i(yumi_a[2]), .hit_o(hit_a[2]), .way_o(way_a[2]),
        .invalidate_i(inv_a[2]), .valid_o(valid_a[2]), .hit_cnt_o(s_hcnt),
        .miss_cnt_o(s_mcnt)
    );

    // One accept + immediate consume on instance d; returns what was seen while v_o was high.
    task automatic lookup(input int d, input logic [127:0] k, input logic with_inv,
                          output logic h, output logic [1:0] w, output logic vo);
        @(negedge clk);
        key_a[d] = k;
        v_a[d]   = 1'b1;
        inv_a[d] = with_inv;
        @(posedge clk);
        #1;
        v_a[d]   = 1'b0;
        inv_a[d] = 1'b0;
        h  = hit_a[d];
        w  = way_a[d];
        vo = vo_a[d];
        @(negedge clk);
        yumi_a[d] = 1'b1;
        @(posedge clk);
        #1;
        yumi_a[d] = 1'b0;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #3;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        for (int d = 0; d < 3; d++) begin
            key_a[d] = '0; v_a[d] = 1'b0; yumi_a[d] = 1'b0; inv_a[d] = 1'b0;
        end
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            total++;
            if (ready_a[d] !== 1'b1 || vo_a[d] !== 1'b0 || hit_a[d] !== 1'b0 ||
                way_a[d] !== 2'd0 || valid_a[d] !== 4'b0000) begin
                bad++;
                $display("FAIL reset[%0d]: got rdy=%b v=%b hit=%b way=%0d valid=%b want 1 0 0 0 0000",
                         d, ready_a[d], vo_a[d], hit_a[d], way_a[d], valid_a[d]);
            end
        end
        total++;
        if (hcnt_a[0] !== 16'd0 || mcnt_a[0] !== 16'd0) begin
            bad++;
            $display("FAIL reset_cnt: got hit=%0d miss=%0d want 0 0", hcnt_a[0], mcnt_a[0]);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_cold_fill();
        logic h, vo;
        logic [1:0] w;
        logic [127:0] keys [4];
        keys = '{KA, KB, KC, KD};
        for (int i = 0; i < 4; i++) begin
            lookup(0, keys[i], 1'b0, h, w, vo);
            total++;
            if (vo !== 1'b1 || h !== 1'b0 || w !== 2'(i)) begin
                bad++;
                $display("FAIL cold_fill[%0d]: got v=%b hit=%b way=%0d want v=1 hit=0 way=%0d",
                         i, vo, h, w, i);
            end
        end
        total++;
        if (valid_a[0] !== 4'b1111 || mcnt_a[0] !== 16'd4) begin
            bad++;
            $display("FAIL cold_fill_state: got valid=%b miss=%0d want 1111 4", valid_a[0], mcnt_a[0]);
        end
        lookup(0, KB, 1'b0, h, w, vo);
        total++;
        if (h !== 1'b1 || w !== 2'd1 || hcnt_a[0] !== 16'd1) begin
            bad++;
            $display("FAIL cold_fill_rehit: got hit=%b way=%0d hcnt=%0d want 1 1 1", h, w, hcnt_a[0]);
        end
    endtask

    task automatic test_lru_evict();
        logic h, vo;
        logic [1:0] w;
        logic [127:0] keys [4];
        keys = '{KA, KB, KC, KD};
        pulse_reset();
        for (int i = 0; i < 4; i++) lookup(0, keys[i], 1'b0, h, w, vo);
        lookup(0, KA, 1'b0, h, w, vo);
        total++;
        if (h !== 1'b1 || w !== 2'd0) begin
            bad++;
            $display("FAIL lru_touch_a: got hit=%b way=%0d want 1 0", h, w);
        end
        lookup(0, KE, 1'b0, h, w, vo);
        total++;
        if (h !== 1'b0 || w !== 2'd1) begin
            bad++;
            $display("FAIL lru_evict_e: got hit=%b way=%0d want 0 1", h, w);
        end
        lookup(0, KB, 1'b0, h, w, vo);
        total++;
        if (h !== 1'b0 || w !== 2'd2) begin
            bad++;
            $display("FAIL lru_evict_b: got hit=%b way=%0d want 0 2", h, w);
        end
        total++;
        if (hcnt_a[0] !== 16'd1 || mcnt_a[0] !== 16'd6) begin
            bad++;
            $display("FAIL lru_counts: got hit=%0d miss=%0d want 1 6", hcnt_a[0], mcnt_a[0]);
        end
    endtask

    task automatic test_round_robin();
        logic h, vo;
        logic [1:0] w;
        logic [127:0] keys [10];
        logic         exp_h [10];
        logic [1:0]   exp_w [10];
        keys  = '{KA, KB, KC, KD, KE, KF, KF, KG, KH, KI};
        exp_h = '{0, 0, 0, 0, 0, 0, 1, 0, 0, 0};
        exp_w = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd1, 2'd2, 2'd3, 2'd0};
        for (int i = 0; i < 10; i++) begin
            lookup(1, keys[i], 1'b0, h, w, vo);
            total++;
            if (h !== exp_h[i] || w !== exp_w[i]) begin
                bad++;
                $display("FAIL round_robin[%0d]: got hit=%b way=%0d want hit=%b way=%0d",
                         i, h, w, exp_h[i], exp_w[i]);
            end
        end
    endtask

    // B sits in way 2 of instance 0 after the eviction sequence.
    task automatic test_invalidate_collision();
        logic h, vo;
        logic [1:0] w;
        lookup(0, KB, 1'b1, h, w, vo);
        total++;
        if (h !== 1'b0 || w !== 2'd0 || valid_a[0] !== 4'b0001) begin
            bad++;
            $display("FAIL inv_collision: got hit=%b way=%0d valid=%b want 0 0 0001", h, w, valid_a[0]);
        end
    endtask

    task automatic test_back_pressure();
        @(negedge clk);
        key_a[0] = KB;
        v_a[0]   = 1'b1;
        @(posedge clk);
        #1;
        key_a[0] = KX;
        total++;
        if (vo_a[0] !== 1'b1 || hit_a[0] !== 1'b1 || way_a[0] !== 2'd0) begin
            bad++;
            $display("FAIL bp_accept: got v=%b hit=%b way=%0d want 1 1 0", vo_a[0], hit_a[0], way_a[0]);
        end
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            inv_a[0] = (c == 1);
            @(posedge clk);
            #1;
            inv_a[0] = 1'b0;
            total++;
            if (vo_a[0] !== 1'b1 || hit_a[0] !== 1'b1 || way_a[0] !== 2'd0 || ready_a[0] !== 1'b0) begin
                bad++;
                $display("FAIL bp_hold[%0d]: got v=%b hit=%b way=%0d rdy=%b want 1 1 0 0",
                         c, vo_a[0], hit_a[0], way_a[0], ready_a[0]);
            end
            if (c >= 1) begin
                total++;
                if (valid_a[0] !== 4'b0000) begin
                    bad++;
                    $display("FAIL bp_valid[%0d]: got %b want 0000", c, valid_a[0]);
                end
            end
        end
        @(negedge clk);
        v_a[0]    = 1'b0;
        yumi_a[0] = 1'b1;
        @(posedge clk);
        #1;
        yumi_a[0] = 1'b0;
        total++;
        if (vo_a[0] !== 1'b0 || ready_a[0] !== 1'b1 || hcnt_a[0] !== 16'd2 || mcnt_a[0] !== 16'd7) begin
            bad++;
            $display("FAIL bp_release: got v=%b rdy=%b hit=%0d miss=%0d want 0 1 2 7",
                     vo_a[0], ready_a[0], hcnt_a[0], mcnt_a[0]);
        end
    endtask

    task automatic test_saturation_reset();
        logic h, vo;
        logic [1:0] w;
        lookup(2, KA, 1'b0, h, w, vo);
        for (int i = 0; i < 5; i++) lookup(2, KA, 1'b0, h, w, vo);
        total++;
        if (s_hcnt !== 2'd3 || s_mcnt !== 2'd1 || h !== 1'b1) begin
            bad++;
            $display("FAIL saturation: got hcnt=%0d mcnt=%0d hit=%b want 3 1 1", s_hcnt, s_mcnt, h);
        end
        @(negedge clk);
        key_a[2] = KA;
        v_a[2]   = 1'b1;
        @(posedge clk);
        #1;
        v_a[2] = 1'b0;
        total++;
        if (vo_a[2] !== 1'b1) begin
            bad++;
            $display("FAIL sat_resp: got v=%b want 1", vo_a[2]);
        end
        #1;
        rst_n = 1'b0;
        #1;
        total++;
        if (vo_a[2] !== 1'b0 || ready_a[2] !== 1'b1 || hit_a[2] !== 1'b0 || way_a[2] !== 2'd0 ||
            valid_a[2] !== 4'b0000 || s_hcnt !== 2'd0 || s_mcnt !== 2'd0) begin
            bad++;
            $display("FAIL async_reset: got v=%b rdy=%b hit=%b way=%0d valid=%b h=%0d m=%0d want 0 1 0 0 0000 0 0",
                     vo_a[2], ready_a[2], hit_a[2], way_a[2], valid_a[2], s_hcnt, s_mcnt);
        end
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_cold_fill();
        test_lru_evict();
        test_round_robin();
        test_invalidate_collision();
        test_back_pressure();
        test_saturation_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
